// File: rtl/pic_pkg.sv
// rtl/pic_pkg.sv - shared types and command encodings for the pic block
// Purpose: init FSM state type and command-byte decode constants used by pic.
// Ports: none (package).
package pic_pkg;

   typedef enum logic [1:0] {
      ST_READY  = 2'd0,
      ST_W_ICW2 = 2'd1,
      ST_W_ICW3 = 2'd2,
      ST_W_ICW4 = 2'd3
   } pic_state_e;

   // OCW2 d[7:5] codes that are honoured; all others are ignored.
   localparam logic [2:0] OCW2_NS_EOI = 3'b001;
   localparam logic [2:0] OCW2_SP_EOI = 3'b011;

   // Command-port d[4:3] select patterns. ICW1 is any byte with d[4]=1.
   localparam logic [1:0] SEL_ICW1 = 2'b10;
   localparam logic [1:0] SEL_OCW2 = 2'b00;
   localparam logic [1:0] SEL_OCW3 = 2'b01;

endpackage

// File: rtl/pic_prio.sv
// rtl/pic_prio.sv - lowest-set-bit finder (bit 0 has highest priority)
// Purpose: combinational priority pick over an 8-bit vector.
// Ports: req_i  - candidate bits
//        vld_o  - at least one bit of req_i is set
//        idx_o  - index of the lowest set bit (0 when vld_o=0)
module pic_prio (
   input  logic [7:0] req_i,
   output logic       vld_o,
   output logic [2:0] idx_o
);

   always_comb begin
      vld_o = 1'b0;
      idx_o = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if (req_i[i] && !vld_o) begin
            vld_o = 1'b1;
            idx_o = 3'(i);
         end
      end
   end

endmodule

// File: rtl/pic.sv
// rtl/pic.sv - 8259A-subset programmable interrupt controller
// Purpose: latches eight request lines, masks and prioritises them (IR0 highest),
//          raises intr, answers inta with a vector and tracks in-service bits.
// Ports: clk/reset_n        - clock, asynchronous active-low reset
//        port/iodin/iodout  - I/O bus address, write data, registered read data
//        iord/iowr          - one-cycle read / write strobes
//        irq                - request lines
//        intr/inta/vector   - CPU interrupt request, acknowledge, acked vector
module pic
   import pic_pkg::*;
#(
   parameter logic [11:0] BASE_PORT  = 12'h020,
   parameter logic [4:0]  RESET_BASE = 5'h01
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [11:0] port,
   input  logic [7:0]  iodin,
   output logic [7:0]  iodout,
   input  logic        iord,
   input  logic        iowr,
   input  logic [7:0]  irq,
   output logic        intr,
   input  logic        inta,
   output logic [7:0]  vector
);

   pic_state_e state_q, state_d;
   logic [7:0] imr_q, imr_d, irr_q, irr_d, isr_q, isr_d, irq_q;
   logic [7:0] vector_q, vector_d, iodout_q, iodout_d;
   logic [4:0] base_q, base_d;
   logic       aeoi_q, aeoi_d, ltim_q, ltim_d, ris_q, ris_d;
   logic       sngl_q, sngl_d, ic4_q, ic4_d, intr_q, intr_d;

   logic       sel_cmd, sel_data;
   logic       isr_vld, win_vld;
   logic [2:0] isr_idx, win_idx;
   logic [7:0] eligible;

   assign sel_cmd  = (port == BASE_PORT);
   assign sel_data = (port == BASE_PORT + 12'd1);

   pic_prio u_isr_prio (.req_i(isr_q), .vld_o(isr_vld), .idx_o(isr_idx));

   // Only requests strictly higher in priority than the current in-service level compete.
   assign eligible = isr_vld ? ((8'd1 << isr_idx) - 8'd1) : 8'hFF;

   pic_prio u_win_prio (.req_i(irr_q & ~imr_q & eligible), .vld_o(win_vld), .idx_o(win_idx));

   always_comb begin
      state_d  = state_q;
      imr_d    = imr_q;
      isr_d    = isr_q;
      base_d   = base_q;
      aeoi_d   = aeoi_q;
      ltim_d   = ltim_q;
      ris_d    = ris_q;
      sngl_d   = sngl_q;
      ic4_d    = ic4_q;
      vector_d = vector_q;
      iodout_d = iodout_q;

      // Edge mode: the ack clears first so a same-cycle new edge on that bit wins.
      if (ltim_q) begin
         irr_d = irq_q;
      end else begin
         irr_d = irr_q;
         if (inta && win_vld) irr_d[win_idx] = 1'b0;
         irr_d = irr_d | (irq & ~irq_q);
      end

      if (iord) begin
         if (sel_cmd)       iodout_d = ris_q ? isr_q : irr_q;
         else if (sel_data) iodout_d = imr_q;
         else               iodout_d = 8'hFF;
      end

      // EOI decodes against the pre-update ISR, then the ack sets its bit.
      if (iowr && sel_cmd && !iodin[4] && state_q == ST_READY) begin
         if (iodin[4:3] == SEL_OCW2) begin
            if (iodin[7:5] == OCW2_NS_EOI && isr_vld) isr_d[isr_idx]    = 1'b0;
            if (iodin[7:5] == OCW2_SP_EOI)            isr_d[iodin[2:0]] = 1'b0;
         end else if (iodin[4:3] == SEL_OCW3 && iodin[1]) begin
            ris_d = iodin[0];
         end
      end

      if (inta) begin
         vector_d = win_vld ? {base_q, win_idx} : {base_q, 3'd7};
         if (win_vld && !aeoi_q) isr_d[win_idx] = 1'b1;
      end

      if (iowr && sel_data) begin
         case (state_q)
            ST_READY:  imr_d = iodin;
            ST_W_ICW2: begin
               base_d  = iodin[7:3];
               state_d = !sngl_q ? ST_W_ICW3 : (ic4_q ? ST_W_ICW4 : ST_READY);
            end
            ST_W_ICW3: state_d = ic4_q ? ST_W_ICW4 : ST_READY;
            default: begin
               aeoi_d  = iodin[1];
               state_d = ST_READY;
            end
         endcase
      end

      // ICW1 overrides any same-cycle ack or request capture.
      if (iowr && sel_cmd && iodin[4]) begin
         imr_d   = 8'h00;
         isr_d   = 8'h00;
         irr_d   = 8'h00;
         ris_d   = 1'b0;
         ltim_d  = iodin[3];
         sngl_d  = iodin[1];
         ic4_d   = iodin[0];
         state_d = ST_W_ICW2;
      end

      intr_d = win_vld && (state_d == ST_READY);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= ST_READY;
         imr_q    <= 8'hFF;
         irr_q    <= 8'h00;
         isr_q    <= 8'h00;
         irq_q    <= 8'h00;
         base_q   <= RESET_BASE;
         aeoi_q   <= 1'b0;
         ltim_q   <= 1'b0;
         ris_q    <= 1'b0;
         sngl_q   <= 1'b0;
         ic4_q    <= 1'b0;
         intr_q   <= 1'b0;
         vector_q <= 8'h00;
         iodout_q <= 8'hFF;
      end else begin
         state_q  <= state_d;
         imr_q    <= imr_d;
         irr_q    <= irr_d;
         isr_q    <= isr_d;
         irq_q    <= irq;
         base_q   <= base_d;
         aeoi_q   <= aeoi_d;
         ltim_q   <= ltim_d;
         ris_q    <= ris_d;
         sngl_q   <= sngl_d;
         ic4_q    <= ic4_d;
         intr_q   <= intr_d;
         vector_q <= vector_d;
         iodout_q <= iodout_d;
      end
   end

   assign intr   = intr_q;
   assign vector = vector_q;
   assign iodout = iodout_q;

endmodule

// File: tb/tb_pic.sv
// tb/tb_pic.sv - self-checking bench for pic
module tb_pic;

   localparam logic [11:0] CMD = 12'h020;
   localparam logic [11:0] DAT = 12'h021;

   logic        clk, reset_n, iord, iowr, inta, intr;
   logic [11:0] port;
   logic [7:0]  iodin, iodout, irq, vector;

   int n_cmp = 0;
   int n_err = 0;

   logic [7:0] exp_q[$];
   string      tag_q[$];

   pic #(.BASE_PORT(12'h020), .RESET_BASE(5'h01)) dut (
      .clk(clk), .reset_n(reset_n), .port(port), .iodin(iodin), .iodout(iodout),
      .iord(iord), .iowr(iowr), .irq(irq), .intr(intr), .inta(inta), .vector(vector)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %02h expected %02h", tag, obs, exp);
      end
   endtask

   task automatic sb_push(input string tag, input logic [7:0] exp);
      exp_q.push_back(exp);
      tag_q.push_back(tag);
   endtask

   task automatic sb_pop(input logic [7:0] obs);
      if (exp_q.size() == 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL scoreboard: observed %02h expected <nothing queued>", obs);
      end else begin
         check(tag_q.pop_front(), obs, exp_q.pop_front());
      end
   endtask

   // All bus tasks start and end 1 time unit after a rising edge.
   task automatic io_wr(input logic [11:0] p, input logic [7:0] d);
      port = p; iodin = d; iowr = 1'b1;
      @(posedge clk); #1;
      iowr = 1'b0;
   endtask

   task automatic io_rd(input logic [11:0] p, input logic [7:0] exp, input string tag);
      sb_push(tag, exp);
      port = p; iord = 1'b1;
      @(posedge clk); #1;
      iord = 1'b0;
      sb_pop(iodout);
   endtask

   task automatic ack(input logic [7:0] exp, input string tag);
      sb_push(tag, exp);
      inta = 1'b1;
      @(posedge clk); #1;
      inta = 1'b0;
      sb_pop(vector);
   endtask

   task automatic wait_intr(input logic exp, input string tag);
      int k = 0;
      while (intr !== exp && k < 20) begin
         @(posedge clk); #1;
         k++;
      end
      check(tag, {7'd0, intr}, {7'd0, exp});
   endtask

   task automatic step(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic init(input logic [7:0] icw4);
      io_wr(CMD, 8'h11);
      io_wr(DAT, 8'h08);
      io_wr(DAT, 8'h04);
      io_wr(DAT, icw4);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      clk = 1'b0; reset_n = 1'b0; port = 12'h000; iodin = 8'h00;
      iord = 1'b0; iowr = 1'b0; inta = 1'b0; irq = 8'h00;
      step(3);
      reset_n = 1'b1;
      step(1);

      // Reset state
      check("rst_intr", {7'd0, intr}, 8'h00);
      check("rst_vector", vector, 8'h00);
      check("rst_iodout", iodout, 8'hFF);
      io_rd(DAT, 8'hFF, "rst_imr");
      io_rd(CMD, 8'h00, "rst_irr");
      io_rd(12'h040, 8'hFF, "other_port");

      // Basic init, IR0 service and non-specific EOI
      init(8'h01);
      io_wr(DAT, 8'hFE);
      io_rd(DAT, 8'hFE, "imr_fe");
      irq[0] = 1'b1;
      wait_intr(1'b1, "ir0_intr");
      irq[0] = 1'b0;
      ack(8'h08, "ir0_vec");
      step(1);
      check("ir0_intr_drop", {7'd0, intr}, 8'h00);
      io_wr(CMD, 8'h0B);
      io_rd(CMD, 8'h01, "ir0_isr");
      io_wr(CMD, 8'h20);
      io_rd(CMD, 8'h00, "ir0_isr_eoi");

      // Fixed priority, blocking by in-service level, specific EOI
      io_wr(DAT, 8'h00);
      irq[3] = 1'b1; irq[1] = 1'b1;
      wait_intr(1'b1, "pri_intr");
      ack(8'h09, "pri_vec1");
      step(2);
      check("pri_blocked", {7'd0, intr}, 8'h00);
      io_rd(CMD, 8'h02, "pri_isr1");
      io_wr(CMD, 8'h61);
      wait_intr(1'b1, "pri_intr3");
      ack(8'h0B, "pri_vec3");
      io_rd(CMD, 8'h08, "pri_isr3");
      io_wr(CMD, 8'h20);
      irq[3] = 1'b0; irq[1] = 1'b0;

      // Masking, and intr one cycle after unmask
      io_wr(DAT, 8'h04);
      irq[2] = 1'b1;
      step(5);
      check("mask_intr", {7'd0, intr}, 8'h00);
      io_wr(DAT, 8'h00);
      check("unmask_t0", {7'd0, intr}, 8'h00);
      step(1);
      check("unmask_t1", {7'd0, intr}, 8'h01);
      ack(8'h0A, "unmask_vec");
      io_wr(CMD, 8'h20);
      irq[2] = 1'b0;

      // Automatic EOI
      init(8'h03);
      irq[5] = 1'b1;
      wait_intr(1'b1, "aeoi_intr1");
      ack(8'h0D, "aeoi_vec1");
      irq[5] = 1'b0;
      io_wr(CMD, 8'h0B);
      io_rd(CMD, 8'h00, "aeoi_isr1");
      irq[5] = 1'b1;
      wait_intr(1'b1, "aeoi_intr2");
      ack(8'h0D, "aeoi_vec2");
      irq[5] = 1'b0;
      io_rd(CMD, 8'h00, "aeoi_isr2");

      // Spurious acknowledge
      step(2);
      io_wr(CMD, 8'h0A);
      io_rd(CMD, 8'h00, "spur_irr_pre");
      ack(8'h0F, "spur_vec");
      io_rd(CMD, 8'h00, "spur_irr_post");
      io_wr(CMD, 8'h0B);
      io_rd(CMD, 8'h00, "spur_isr_post");

      // ICW1 restarts init mid-sequence; intr held low until READY
      io_wr(CMD, 8'h11);
      io_wr(DAT, 8'h08);
      io_wr(CMD, 8'h13);
      irq[1] = 1'b1;
      step(4);
      check("init_intr_low", {7'd0, intr}, 8'h00);
      io_wr(DAT, 8'h70);
      io_wr(DAT, 8'h01);
      irq[0] = 1'b1;
      step(3);
      check("reinit_intr", {7'd0, intr}, 8'h01);
      ack(8'h70, "reinit_vec0");
      io_wr(CMD, 8'h20);
      wait_intr(1'b1, "reinit_intr1");
      ack(8'h71, "reinit_vec1");
      io_wr(CMD, 8'h20);
      irq = 8'h00;
      step(2);

      // Asynchronous reset while intr is high
      irq[0] = 1'b1;
      wait_intr(1'b1, "arst_intr_pre");
      io_rd(DAT, 8'h00, "arst_imr_pre");
      #2 reset_n = 1'b0;
      #1;
      check("arst_intr", {7'd0, intr}, 8'h00);
      check("arst_iodout", iodout, 8'hFF);
      check("arst_vector", vector, 8'h00);
      @(posedge clk); #1;
      reset_n = 1'b1;
      irq = 8'h00;
      io_rd(DAT, 8'hFF, "arst_imr");

      if (exp_q.size() != 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL scoreboard_drain: observed %0d left expected 0", exp_q.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
